// File: rtl/sbox_lut.sv
// sbox_lut: AES SubBytes for one byte lane with a registered result and valid flag.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : byte_in (and inv) are sampled this cycle
//   byte_in   : byte to substitute
//   inv       : 1 selects the inverse S-box (only when SBOX_INV_EN is defined)
//   sbyte     : registered substituted byte, RESET_VALUE after reset
//   out_valid : sbyte was produced from the previous cycle's valid input
// Define SBOX_INV_EN to add the inv port and the inverse S-box path.
module sbox_lut #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] byte_in,
`ifdef SBOX_INV_EN
  input  logic       inv,
`endif
  output logic [7:0] sbyte,
  output logic       out_valid
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? t : 8'h00);
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse and naturally maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      r = e[i] ? gf_mul(r, a) : r;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  logic [7:0] sub;
  logic [7:0] sbyte_d, sbyte_q;
  logic       valid_d, valid_q;

`ifdef SBOX_INV_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  always_comb sub = inv ? inv_sbox(byte_in) : fwd_sbox(byte_in);
`else
  always_comb sub = fwd_sbox(byte_in);
`endif

  always_comb begin
    sbyte_d = in_valid ? sub : sbyte_q;
    valid_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbyte_q <= RESET_VALUE;
      valid_q <= 1'b0;
    end else begin
      sbyte_q <= sbyte_d;
      valid_q <= valid_d;
    end
  end

  assign sbyte     = sbyte_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_sbox_lut.sv
// tb_sbox_lut: scoreboard bench for sbox_lut against the FIPS-197 table.
module tb_sbox_lut;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       inv = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic [7:0] sbyte;
  logic       out_valid;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q[$];

  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [7:0] spot_in  [7] = '{8'h00, 8'hff, 8'haa, 8'hf0, 8'h0f, 8'h01, 8'h53};
  logic [7:0] spot_exp [7] = '{8'h63, 8'h16, 8'hac, 8'h8c, 8'h76, 8'h7c, 8'hed};

  always #5 clk = ~clk;

  sbox_lut dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .byte_in(byte_in),
`ifdef SBOX_INV_EN
    .inv(inv),
`endif
    .sbyte(sbyte),
    .out_valid(out_valid)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [7:0] b, input logic [7:0] e);
    in_valid = 1'b1;
    byte_in  = b;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h with no pending expectation at %0t", sbyte, $time);
      end else begin
        chk("scoreboard", sbyte, q.pop_front());
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset_sbyte", sbyte, 8'h00);
    chk("reset_valid", {7'd0, out_valid}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("idle_sbyte", sbyte, 8'h00);
      chk("idle_valid", {7'd0, out_valid}, 8'h00);
    end
    for (int i = 0; i < 7; i++) begin
      issue(spot_in[i], spot_exp[i]);
      chk("spot_latency", sbyte, spot_exp[i]);
      chk("spot_valid", {7'd0, out_valid}, 8'h01);
    end
    for (int i = 0; i < 256; i++) issue(8'(i), sbox_t[i]);
    issue(8'haa, 8'hac);
    issue(8'haa, 8'hac);
    chk("repeat_aa", sbyte, 8'hac);
    @(posedge clk);
    #1;
    chk("stream_end_valid", {7'd0, out_valid}, 8'h00);
    issue(8'hf0, 8'h8c);
    byte_in = 8'h0f;
    @(posedge clk);
    #1;
    chk("gate_hold", sbyte, 8'h8c);
    chk("gate_valid", {7'd0, out_valid}, 8'h00);
    in_valid = 1'b1;
    byte_in  = 8'h53;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_reset_valid", {7'd0, out_valid}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_sbyte", sbyte, 8'h00);
    chk("async_rst_valid", {7'd0, out_valid}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    issue(8'h01, 8'h7c);
    chk("post_reset", sbyte, 8'h7c);
`ifdef SBOX_INV_EN
    inv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      issue(spot_exp[i], spot_in[i]);
      chk("inv_spot", sbyte, spot_in[i]);
    end
    for (int i = 0; i < 256; i++) issue(sbox_t[i], 8'(i));
    inv = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sbox_lut.md
Name: sbox_lut

Overview:
- AES (FIPS-197) SubBytes substitution for a single byte, with one registered output stage and a valid flag.
- Used by the AES round datapath; one instance per byte lane.
- Outputs register on the clock edge after the input is presented.

Parameters:
- RESET_VALUE, 8'h00, value driven on sbyte while reset is asserted and before the first valid input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  byte_in is valid this cycle.
- byte_in  input  8  byte to substitute.
- inv  input  1  select inverse S-box. Present only when SBOX_INV_EN is defined.
- sbyte  output  8  substituted byte, registered.
- out_valid  output  1  sbyte holds a fresh result, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, clk / rst_n.
- Function: S(x) = affine transform of the multiplicative inverse of x in GF(2^8), modulo x^8+x^4+x^3+x+1, with 0 mapped to 0. Affine constant is 8'h63.
- Implementation style is free: a 256-entry case table or a GF inversion plus affine logic. Every one of the 256 results must match the FIPS-197 forward S-box bit-exactly.
- Reset (rst_n low, asynchronous, no clock required):
  - sbyte = RESET_VALUE.
  - out_valid = 0.
  - Both hold until the first rising edge of clk with rst_n high.
- Latency: exactly 1 cycle. If in_valid=1 at rising edge N, then from edge N on, sbyte = S(byte_in sampled at N) and out_valid = 1.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - sbyte holds its previous value (no X, no recompute).
- Back-to-back valid inputs give one result per cycle; no stalls, no backpressure.
- Reset released mid-stream: the first edge after release samples normally. Nothing is carried over from before reset.
- Reset asserted while out_valid=1: out_valid and sbyte clear immediately, without waiting for a clock edge.
- byte_in is fully decoded: all 256 codes are legal, with no X-propagation paths.
- in_valid or byte_in at X/Z is not checked; behaviour is undefined.

Optional Feature:
- Macro SBOX_INV_EN.
- Defined:
  - Port inv is added and sampled with byte_in when in_valid=1.
  - inv=1: sbyte = InvS(byte_in), the FIPS-197 inverse S-box (inverse affine, then GF inverse). InvS(S(x)) = x for all x.
  - inv=0: forward S-box.
  - Latency and valid behaviour are identical to the forward path.
- Undefined:
  - Port inv does not exist.
  - Forward S-box only; no inverse logic is synthesized.

Test Plan:
- Reset: rst_n=0 asynchronously with no clock edge -> sbyte=8'h00, out_valid=0. Release, hold in_valid=0 for 3 cycles -> outputs unchanged.
- Forward spot checks, each one cycle with in_valid=1: 8'h00->8'h63, 8'hFF->8'h16, 8'hAA->8'hAC, 8'hF0->8'h8C, 8'h0F->8'h76, 8'h01->8'h7C, 8'h53->8'hED. Each result appears 1 cycle after the sampling edge with out_valid=1.
- Streaming: drive 8'h00..8'hFF on consecutive cycles with in_valid=1 -> 256 consecutive out_valid=1 cycles, each matching the FIPS-197 table with 1-cycle lag. Repeat 8'hAA twice -> 8'hAC twice.
- Valid gating: present 8'hF0 (valid), then 8'h0F with in_valid=0 -> sbyte stays 8'h8C, out_valid=0.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1 -> sbyte=8'h00 and out_valid=0 before the next edge.
- SBOX_INV_EN build, inv=1: 8'h63->8'h00, 8'h16->8'hFF, 8'hAC->8'hAA, 8'hED->8'h53. Sweep all 256 values through forward then inverse -> identity.
